// File: rtl/arb_pkg.sv
// Shared types and constants for the two-source round-robin arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    HOLD_A = 2'b01,
    HOLD_B = 2'b10
  } state_t;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  // Holding state that corresponds to a given winning source.
  function automatic state_t hold_state(input logic src);
    return (src == SRC_B) ? HOLD_B : HOLD_A;
  endfunction

endpackage

// File: rtl/arb_rr2_pick.sv
// Combinational round-robin winner selection between two eligible sources.
module arb_rr2_pick
  import arb_pkg::*;
(
  input  logic elig_a,
  input  logic elig_b,
  input  logic last,
  output logic grant,
  output logic winner
);

  // On a tie, the source that was not served last wins; otherwise the only eligible one.
  always_comb begin
    grant  = elig_a | elig_b;
    winner = SRC_A;
    if (elig_a && elig_b) begin
      winner = ~last;
    end else if (elig_b) begin
      winner = SRC_B;
    end
  end

endmodule

// File: rtl/arbitro_mux_rr.sv
// Round-robin arbiter and output register feeding the downstream 2:1 mux select.
module arbitro_mux_rr
  import arb_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic [WIDTH-1:0] data_a,
  output logic             ack_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_b,
  output logic             ack_b,
  output logic             sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  output logic [CW-1:0]    cnt_a,
  output logic [CW-1:0]    cnt_b
);

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic             sel_q, sel_d;
  logic             src_q, src_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             ack_a_q, ack_a_d;
  logic             ack_b_q, ack_b_d;
  logic [CW-1:0]    cnt_a_q, cnt_a_d;
  logic [CW-1:0]    cnt_b_q, cnt_b_d;

  logic             slot_free;
  logic             elig_a, elig_b;
  logic             grant, winner;
  logic [WIDTH-1:0] mux_data;

  // A request seen during its own ack cycle is stale, so it must not be captured again.
  assign elig_a    = req_a & ~ack_a_q;
  assign elig_b    = req_b & ~ack_b_q;
  assign slot_free = (state_q == IDLE) | out_ready;

  arb_rr2_pick u_pick (
    .elig_a (elig_a),
    .elig_b (elig_b),
    .last   (last_q),
    .grant  (grant),
    .winner (winner)
  );

  // 2:1 mux (s=0 -> a, s=1 -> b); winner is known whenever it matters, so idle X data is masked.
  assign mux_data = winner ? data_b : data_a;

  // Next-state: capture on a grant, drain to IDLE when free and idle, otherwise hold.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    sel_d   = sel_q;
    src_d   = src_q;
    data_d  = data_q;
    ack_a_d = 1'b0;
    ack_b_d = 1'b0;
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    if (slot_free && grant) begin
      state_d = hold_state(winner);
      last_d  = winner;
      sel_d   = winner;
      src_d   = winner;
      data_d  = mux_data;
      if (winner == SRC_B) begin
        ack_b_d = 1'b1;
        cnt_b_d = cnt_b_q + CW'(1);
      end else begin
        ack_a_d = 1'b1;
        cnt_a_d = cnt_a_q + CW'(1);
      end
    end else if (slot_free) begin
      state_d = IDLE;
    end
  end

  // State register; last resets to B so A wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= SRC_B;
      sel_q   <= SRC_A;
      src_q   <= SRC_A;
      data_q  <= '0;
      ack_a_q <= 1'b0;
      ack_b_q <= 1'b0;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      src_q   <= src_d;
      data_q  <= data_d;
      ack_a_q <= ack_a_d;
      ack_b_q <= ack_b_d;
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
    end
  end

  assign out_valid = (state_q != IDLE);
  assign out_src   = src_q;
  assign sel       = sel_q;
  assign out_data  = data_q;
  assign ack_a     = ack_a_q;
  assign ack_b     = ack_b_q;
  assign cnt_a     = cnt_a_q;
  assign cnt_b     = cnt_b_q;

endmodule
